// File: rtl/usb_tx_framer.sv
// usb_tx_framer
//
// Frames a byte stream from an upstream serializer for an FT245 synchronous
// FIFO bus. Input bytes, each tagged with a start-of-frame flag, are buffered
// in a small FIFO. Each frame goes out on the bus as
//    START_FLAG, payload bytes, [checksum], STOP_FLAG
// A frame ends after FRAME_LEN payload bytes, or earlier when the next
// sof-tagged byte reaches the FIFO head.
//
// Build option:
//    FMCW_TX_CHECKSUM_EN  when defined, an XOR of the frame's payload bytes is
//                         sent just before STOP_FLAG.
//
// Ports:
//    clk_i        single clock, also the FT245 bus clock
//    rst_n_i      asynchronous active-low reset (release synchronized inside)
//    data_i       payload byte from upstream
//    valid_i      data_i valid; upstream cannot be stalled
//    sof_i        with valid_i, marks the first payload byte of a frame
//    ft_txe_n_i   FT245 has room for a byte (active-low)
//    ft_wr_n_o    FT245 write strobe (active-low), low while a byte is pending
//    ft_data_o    FT245 write data
//    overflow_o   sticky: an input byte was dropped on a full FIFO
//    frame_cnt_o  number of STOP_FLAG bytes accepted by the FT245, wraps
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | wait for a sof-tagged byte at the FIFO head, drop others
// S_START   | load START_FLAG into the output stage, clear counter/checksum
// S_PAYLOAD | move FIFO bytes into the output stage until the frame ends
// S_CHECKSUM| load the payload XOR (FMCW_TX_CHECKSUM_EN builds only)
// S_STOP    | load STOP_FLAG, then return to S_IDLE
module usb_tx_framer #(
   parameter int               USBDW      = 8,
   parameter int               FRAME_LEN  = 4096,
   parameter int               FIFO_AW    = 4,
   parameter logic [USBDW-1:0] START_FLAG = 'hFF,
   parameter logic [USBDW-1:0] STOP_FLAG  = 'h8F
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [USBDW-1:0] data_i,
   input  logic             valid_i,
   input  logic             sof_i,
   input  logic             ft_txe_n_i,
   output logic             ft_wr_n_o,
   output logic [USBDW-1:0] ft_data_o,
   output logic             overflow_o,
   output logic [15:0]      frame_cnt_o
);

   localparam int          DEPTH    = 2 ** FIFO_AW;
   localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_PAYLOAD,
`ifdef FMCW_TX_CHECKSUM_EN
      S_CHECKSUM,
`endif
      S_STOP
   } state_t;

`ifdef FMCW_TX_CHECKSUM_EN
   localparam state_t S_FRAME_END = S_CHECKSUM;
`else
   localparam state_t S_FRAME_END = S_STOP;
`endif

   // Reset asserts asynchronously and releases one edge later, so the
   // datapath is live from the second clock edge after rst_n_i rises.
   logic rst_sync_q, rst_sync_d;
   logic rst_int_n;

   always_comb begin
      rst_sync_d = 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) rst_sync_q <= 1'b0;
      else          rst_sync_q <= rst_sync_d;
   end

   assign rst_int_n = rst_sync_q;

   // Input FIFO: entries are {sof, data}; pointers carry one wrap bit.
   logic [USBDW:0]   mem_q [DEPTH];
   logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;
   logic             fifo_empty, fifo_full;
   logic             push, pop;
   logic [USBDW:0]   head;
   logic             head_sof;
   logic [USBDW-1:0] head_data;

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                       (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
   // Full is judged before any same-cycle pop, so a byte arriving on a full
   // FIFO is dropped even when a slot frees up on that edge.
   assign push       = valid_i && !fifo_full;
   assign head       = mem_q[rd_ptr_q[FIFO_AW-1:0]];
   assign head_sof   = head[USBDW];
   assign head_data  = head[USBDW-1:0];

   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= {sof_i, data_i};
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q + (push ? 1'b1 : 1'b0);
      rd_ptr_d = rd_ptr_q + (pop  ? 1'b1 : 1'b0);
   end

   // Output stage: one pending byte. A new byte may be loaded when the stage
   // is empty or its byte is leaving on this edge.
   logic             pend_q, pend_d;
   logic [USBDW-1:0] data_q, data_d;
   logic             stop_pend_q, stop_pend_d;
   logic             xfer, stage_free;
   logic             load, load_stop;
   logic [USBDW-1:0] load_data;

   assign xfer       = pend_q && !ft_txe_n_i;
   assign stage_free = !pend_q || xfer;

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
`ifdef FMCW_TX_CHECKSUM_EN
   logic [USBDW-1:0] xor_q, xor_d;
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pop       = 1'b0;
      load      = 1'b0;
      load_stop = 1'b0;
      load_data = '0;
`ifdef FMCW_TX_CHECKSUM_EN
      xor_d     = xor_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               if (head_sof) state_d = S_START;
               else          pop     = 1'b1;
            end
         end
         S_START: begin
            if (stage_free) begin
               load      = 1'b1;
               load_data = START_FLAG;
               cnt_d     = '0;
`ifdef FMCW_TX_CHECKSUM_EN
               xor_d     = '0;
`endif
               state_d   = S_PAYLOAD;
            end
         end
         S_PAYLOAD: begin
            if (!fifo_empty) begin
               // A sof byte after at least one payload byte belongs to the
               // next frame: close this one and leave it at the head.
               if (head_sof && (cnt_q != 16'd0)) begin
                  state_d = S_FRAME_END;
               end else if (stage_free) begin
                  pop       = 1'b1;
                  load      = 1'b1;
                  load_data = head_data;
                  cnt_d     = cnt_q + 16'd1;
`ifdef FMCW_TX_CHECKSUM_EN
                  xor_d     = xor_q ^ head_data;
`endif
                  if (cnt_q == LAST_IDX) state_d = S_FRAME_END;
               end
            end
         end
`ifdef FMCW_TX_CHECKSUM_EN
         S_CHECKSUM: begin
            if (stage_free) begin
               load      = 1'b1;
               load_data = xor_q;
               state_d   = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (stage_free) begin
               load      = 1'b1;
               load_stop = 1'b1;
               load_data = STOP_FLAG;
               state_d   = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   logic        ovf_q, ovf_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;

   always_comb begin
      pend_d      = pend_q;
      data_d      = data_q;
      stop_pend_d = stop_pend_q;
      if (load) begin
         pend_d      = 1'b1;
         data_d      = load_data;
         stop_pend_d = load_stop;
      end else if (xfer) begin
         pend_d      = 1'b0;
         stop_pend_d = 1'b0;
      end
      ovf_d       = ovf_q | (valid_i & fifo_full);
      frame_cnt_d = frame_cnt_q + ((xfer && stop_pend_q) ? 16'd1 : 16'd0);
   end

   always_ff @(posedge clk_i or negedge rst_int_n) begin
      if (!rst_int_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         pend_q      <= 1'b0;
         data_q      <= '0;
         stop_pend_q <= 1'b0;
         ovf_q       <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pend_q      <= pend_d;
         data_q      <= data_d;
         stop_pend_q <= stop_pend_d;
         ovf_q       <= ovf_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

`ifdef FMCW_TX_CHECKSUM_EN
   always_ff @(posedge clk_i or negedge rst_int_n) begin
      if (!rst_int_n) xor_q <= '0;
      else            xor_q <= xor_d;
   end
`endif

   assign ft_wr_n_o   = ~pend_q;
   assign ft_data_o   = data_q;
   assign overflow_o  = ovf_q;
   assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_usb_tx_framer.sv
module tb_usb_tx_framer;

   logic        clk = 1'b0;
   logic        rst_n_i = 1'b1;
   logic [7:0]  data_i = '0;
   logic        valid_i = 1'b0;
   logic        sof_i = 1'b0;
   logic        ft_txe_n_i = 1'b1;
   logic        ft_wr_n_o;
   logic [7:0]  ft_data_o;
   logic        overflow_o;
   logic [15:0] frame_cnt_o;

   int n_chk = 0;
   int n_fail = 0;

   logic [7:0] got[$];
   logic [7:0] exp_q[$];

   usb_tx_framer #(
      .USBDW(8), .FRAME_LEN(4), .FIFO_AW(4),
      .START_FLAG(8'hFF), .STOP_FLAG(8'h8F)
   ) dut (
      .clk_i(clk), .rst_n_i(rst_n_i), .data_i(data_i), .valid_i(valid_i),
      .sof_i(sof_i), .ft_txe_n_i(ft_txe_n_i), .ft_wr_n_o(ft_wr_n_o),
      .ft_data_o(ft_data_o), .overflow_o(overflow_o), .frame_cnt_o(frame_cnt_o)
   );

   always #5 clk = ~clk;

   // Inputs change 1ns after a rising edge, so at the falling edge they show
   // what the next rising edge will see.
   always @(negedge clk) begin
      if (rst_n_i === 1'b1 && ft_wr_n_o === 1'b0 && ft_txe_n_i === 1'b0)
         got.push_back(ft_data_o);
   end

   task automatic do_reset();
      rst_n_i = 1'b0;
      valid_i = 1'b0;
      sof_i   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      got.delete();
      exp_q.delete();
      rst_n_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic s, input logic [7:0] d);
      valid_i = 1'b1;
      sof_i   = s;
      data_i  = d;
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      sof_i   = 1'b0;
   endtask

   task automatic push_frame(input logic [7:0] first, input int n);
      for (int i = 0; i < n; i++) push(i == 0, first + 8'(i));
   endtask

   task automatic append_frame(input logic [7:0] first, input int n);
      logic [7:0] x;
      x = 8'h00;
      exp_q.push_back(8'hFF);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(first + 8'(i));
         x = x ^ (first + 8'(i));
      end
`ifdef FMCW_TX_CHECKSUM_EN
      exp_q.push_back(x);
`endif
      exp_q.push_back(8'h8F);
   endtask

   task automatic wait_bytes(input int n, input int budget);
      int k;
      k = 0;
      while (got.size() < n && k < budget) begin
         @(posedge clk);
         #1;
         k++;
      end
      repeat (10) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      ft_txe_n_i = 1'b0;
      #3;
      rst_n_i = 1'b0;
      #2;
      n_chk++; if (ft_wr_n_o !== 1'b1) begin n_fail++; $display("FAIL reset wr_n: got %b, required 1", ft_wr_n_o); end
      n_chk++; if (ft_data_o !== 8'h00) begin n_fail++; $display("FAIL reset data: got %h, required 00", ft_data_o); end
      n_chk++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL reset overflow: got %b, required 0", overflow_o); end
      n_chk++; if (frame_cnt_o !== 16'd0) begin n_fail++; $display("FAIL reset frame_cnt: got %0d, required 0", frame_cnt_o); end
      do_reset();
      n_chk++; if (ft_wr_n_o !== 1'b1) begin n_fail++; $display("FAIL idle wr_n: got %b, required 1", ft_wr_n_o); end
   endtask

   task automatic test_basic();
      do_reset();
      ft_txe_n_i = 1'b0;
      push_frame(8'h01, 4);
      append_frame(8'h01, 4);
      wait_bytes(exp_q.size(), 200);
      n_chk++; if (got.size() !== exp_q.size()) begin n_fail++; $display("FAIL basic count: got %0d, required %0d", got.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         n_chk++; if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL basic byte %0d: got %h, required %h", i, got[i], exp_q[i]); end
      end
      n_chk++; if (frame_cnt_o !== 16'd1) begin n_fail++; $display("FAIL basic frame_cnt: got %0d, required 1", frame_cnt_o); end
      n_chk++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL basic overflow: got %b, required 0", overflow_o); end
   endtask

   task automatic test_resync();
      do_reset();
      ft_txe_n_i = 1'b0;
      push(1'b0, 8'h55);
      push(1'b0, 8'h66);
      push_frame(8'h01, 4);
      append_frame(8'h01, 4);
      wait_bytes(exp_q.size(), 200);
      n_chk++; if (got.size() !== exp_q.size()) begin n_fail++; $display("FAIL resync count: got %0d, required %0d", got.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         n_chk++; if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL resync byte %0d: got %h, required %h", i, got[i], exp_q[i]); end
      end
      n_chk++; if (frame_cnt_o !== 16'd1) begin n_fail++; $display("FAIL resync frame_cnt: got %0d, required 1", frame_cnt_o); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      ft_txe_n_i = 1'b0;
      push_frame(8'h01, 2);
      push_frame(8'h0A, 4);
      append_frame(8'h01, 2);
      append_frame(8'h0A, 4);
      wait_bytes(exp_q.size(), 300);
      n_chk++; if (got.size() !== exp_q.size()) begin n_fail++; $display("FAIL short count: got %0d, required %0d", got.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         n_chk++; if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL short byte %0d: got %h, required %h", i, got[i], exp_q[i]); end
      end
      n_chk++; if (frame_cnt_o !== 16'd2) begin n_fail++; $display("FAIL short frame_cnt: got %0d, required 2", frame_cnt_o); end
   endtask

   task automatic test_latency();
      logic found;
      do_reset();
      ft_txe_n_i = 1'b0;
      push(1'b1, 8'h01);
      found = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         if (!found && ft_wr_n_o === 1'b0 && ft_data_o === 8'hFF) found = 1'b1;
         @(posedge clk);
         #1;
      end
      if (!found && ft_wr_n_o === 1'b0 && ft_data_o === 8'hFF) found = 1'b1;
      n_chk++; if (found !== 1'b1) begin n_fail++; $display("FAIL latency: START_FLAG seen %b, required 1 within 3 cycles", found); end
   endtask

   task automatic test_overflow();
      logic stable;
      do_reset();
      ft_txe_n_i = 1'b1;
      push_frame(8'h01, 20);
      stable = 1'b1;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (ft_data_o !== 8'hFF || ft_wr_n_o !== 1'b0) stable = 1'b0;
      end
      n_chk++; if (stable !== 1'b1) begin n_fail++; $display("FAIL hold stable: got %b (data %h wr_n %b), required 1", stable, ft_data_o, ft_wr_n_o); end
      n_chk++; if (got.size() !== 0) begin n_fail++; $display("FAIL hold transfers: got %0d, required 0", got.size()); end
      n_chk++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL overflow set: got %b, required 1", overflow_o); end
      ft_txe_n_i = 1'b0;
      append_frame(8'h01, 4);
      wait_bytes(exp_q.size(), 200);
      repeat (40) @(posedge clk);
      #1;
      n_chk++; if (got.size() !== exp_q.size()) begin n_fail++; $display("FAIL overflow count: got %0d, required %0d", got.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         n_chk++; if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL overflow byte %0d: got %h, required %h", i, got[i], exp_q[i]); end
      end
      n_chk++; if (frame_cnt_o !== 16'd1) begin n_fail++; $display("FAIL overflow frame_cnt: got %0d, required 1", frame_cnt_o); end
      n_chk++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL overflow sticky: got %b, required 1", overflow_o); end
   endtask

   task automatic test_reset_midframe();
      do_reset();
      ft_txe_n_i = 1'b0;
      push_frame(8'h01, 4);
      append_frame(8'h01, 4);
      wait_bytes(exp_q.size(), 200);
      n_chk++; if (frame_cnt_o !== 16'd1) begin n_fail++; $display("FAIL pre-reset frame_cnt: got %0d, required 1", frame_cnt_o); end
      got.delete();
      exp_q.delete();
      push_frame(8'h01, 4);
      begin
         int k;
         k = 0;
         while (got.size() < 3 && k < 100) begin
            @(posedge clk);
            #1;
            k++;
         end
      end
      rst_n_i = 1'b0;
      #1;
      n_chk++; if (ft_wr_n_o !== 1'b1) begin n_fail++; $display("FAIL midreset wr_n: got %b, required 1", ft_wr_n_o); end
      n_chk++; if (ft_data_o !== 8'h00) begin n_fail++; $display("FAIL midreset data: got %h, required 00", ft_data_o); end
      n_chk++; if (frame_cnt_o !== 16'd0) begin n_fail++; $display("FAIL midreset frame_cnt: got %0d, required 0", frame_cnt_o); end
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'h01);
      exp_q.push_back(8'h02);
      n_chk++; if (got.size() !== exp_q.size()) begin n_fail++; $display("FAIL midreset count: got %0d, required %0d", got.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         n_chk++; if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL midreset byte %0d: got %h, required %h", i, got[i], exp_q[i]); end
      end
      do_reset();
      push_frame(8'h07, 4);
      append_frame(8'h07, 4);
      wait_bytes(exp_q.size(), 200);
      n_chk++; if (got.size() !== exp_q.size()) begin n_fail++; $display("FAIL restart count: got %0d, required %0d", got.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         n_chk++; if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL restart byte %0d: got %h, required %h", i, got[i], exp_q[i]); end
      end
      n_chk++; if (frame_cnt_o !== 16'd1) begin n_fail++; $display("FAIL restart frame_cnt: got %0d, required 1", frame_cnt_o); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_resync();
      test_back_to_back();
      test_latency();
      test_overflow();
      test_reset_midframe();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
